// File: rtl/mem_arb2.sv
// Two-client arbiter in front of a single-port synchronous data memory.
// Define ARB2_FIXED_PRI_EN for strict client-0 priority instead of round-robin.
module mem_arb2 #(
   parameter int W  = 16,
   parameter int AW = 10,
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          client_req_0,
   input  logic          client_read_0,
   input  logic [AW-1:0] client_addr_0,
   input  logic [W-1:0]  client_wdata_0,
   input  logic [TW-1:0] client_tag_0,
   output logic          client_gnt_0,
   input  logic          client_req_1,
   input  logic          client_read_1,
   input  logic [AW-1:0] client_addr_1,
   input  logic [W-1:0]  client_wdata_1,
   input  logic [TW-1:0] client_tag_1,
   output logic          client_gnt_1,
   output logic          client_rvalid,
   output logic          client_rid,
   output logic [TW-1:0] client_rtag,
   output logic [W-1:0]  client_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [W-1:0]  mem_wdata,
   input  logic [W-1:0]  mem_rdata
);

   logic          xfer;
   logic          win_read;
   logic          win_id;
   logic [AW-1:0] win_addr;
   logic [W-1:0]  win_wdata;
   logic [TW-1:0] win_tag;

   logic          rd_v1;
   logic          rd_id1;
   logic [TW-1:0] rd_tag1;

`ifdef ARB2_FIXED_PRI_EN
   assign client_gnt_0 = rst_n & client_req_0;
   assign client_gnt_1 = rst_n & client_req_1 & ~client_req_0;
`else
   // last_gnt: 1 means client 1 won the most recent transfer
   logic last_gnt;

   assign client_gnt_0 = rst_n & client_req_0 & (~client_req_1 | last_gnt);
   assign client_gnt_1 = rst_n & client_req_1 & (~client_req_0 | ~last_gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
      end else if (xfer) begin
         last_gnt <= client_gnt_1;
      end
   end
`endif

   assign xfer = client_gnt_0 | client_gnt_1;

   always_comb begin
      win_read  = 1'b0;
      win_id    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      win_tag   = '0;
      unique case (1'b1)
         client_gnt_0: begin
            win_read  = client_read_0;
            win_id    = 1'b0;
            win_addr  = client_addr_0;
            win_wdata = client_wdata_0;
            win_tag   = client_tag_0;
         end
         client_gnt_1: begin
            win_read  = client_read_1;
            win_id    = 1'b1;
            win_addr  = client_addr_1;
            win_wdata = client_wdata_1;
            win_tag   = client_tag_1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_v1     <= 1'b0;
         rd_id1    <= 1'b0;
         rd_tag1   <= '0;
      end else begin
         mem_en <= xfer;
         mem_we <= xfer & ~win_read;
         rd_v1  <= xfer & win_read;
         if (xfer) begin
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            rd_id1    <= win_id;
            rd_tag1   <= win_tag;
         end
      end
   end

   // Response stage lines up with the memory's one-cycle read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         client_rvalid <= 1'b0;
         client_rid    <= 1'b0;
         client_rtag   <= '0;
      end else begin
         client_rvalid <= rd_v1;
         if (rd_v1) begin
            client_rid  <= rd_id1;
            client_rtag <= rd_tag1;
         end
      end
   end

   assign client_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arb2.sv
// Scoreboard bench for mem_arb2: directed client traffic, memory model,
// queued expectations checked by a negedge monitor.
module tb_mem_arb2;

   localparam int W  = 16;
   localparam int AW = 10;
   localparam int TW = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  wdata;
   } cmd_t;

   typedef struct packed {
      logic          id;
      logic [TW-1:0] tag;
      logic [W-1:0]  data;
   } rd_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, rd0, req1, rd1;
   logic [AW-1:0] a0, a1;
   logic [W-1:0]  d0, d1;
   logic [TW-1:0] t0, t1;
   logic          gnt0, gnt1;
   logic          client_rvalid, client_rid;
   logic [TW-1:0] client_rtag;
   logic [W-1:0]  client_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;

   logic [W-1:0]  mem [0:(1<<AW)-1];
   logic [W-1:0]  ref_mem [0:(1<<AW)-1];

   cmd_t cmd_q[$];
   rd_t  rd_q[$];

   int   tests = 0;
   int   fails = 0;
   logic m_ptr;

   mem_arb2 #(.W(W), .AW(AW), .TW(TW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .client_req_0   (req0),
      .client_read_0  (rd0),
      .client_addr_0  (a0),
      .client_wdata_0 (d0),
      .client_tag_0   (t0),
      .client_gnt_0   (gnt0),
      .client_req_1   (req1),
      .client_read_1  (rd1),
      .client_addr_1  (a1),
      .client_wdata_1 (d1),
      .client_tag_1   (t1),
      .client_gnt_1   (gnt1),
      .client_rvalid  (client_rvalid),
      .client_rid     (client_rid),
      .client_rtag    (client_rtag),
      .client_rdata   (client_rdata),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_en) begin
            if (cmd_q.size() == 0) begin
               chk("mem_en_unexpected", 32'(mem_en), 32'd0);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               chk("mem_we", 32'(mem_we), 32'(c.we));
               chk("mem_addr", 32'(mem_addr), 32'(c.addr));
               if (c.we) chk("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
            end
         end
         if (client_rvalid) begin
            if (rd_q.size() == 0) begin
               chk("rvalid_unexpected", 32'(client_rvalid), 32'd0);
            end else begin
               rd_t r;
               r = rd_q.pop_front();
               chk("rid", 32'(client_rid), 32'(r.id));
               chk("rtag", 32'(client_rtag), 32'(r.tag));
               chk("rdata", 32'(client_rdata), 32'(r.data));
            end
         end
      end
   end

   task automatic push(input logic id, input logic rd,
                       input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [TW-1:0] t);
      cmd_t c;
      rd_t  r;
      c.we    = ~rd;
      c.addr  = a;
      c.wdata = d;
      cmd_q.push_back(c);
      if (rd) begin
         r.id   = id;
         r.tag  = t;
         r.data = ref_mem[a];
         rd_q.push_back(r);
      end else begin
         ref_mem[a] = d;
      end
   endtask

   task automatic drive(input logic r0_, input logic rd0_,
                        input logic [AW-1:0] a0_, input logic [W-1:0] d0_,
                        input logic [TW-1:0] t0_,
                        input logic r1_, input logic rd1_,
                        input logic [AW-1:0] a1_, input logic [W-1:0] d1_,
                        input logic [TW-1:0] t1_);
      @(posedge clk);
      #1;
      req0 = r0_; rd0 = rd0_; a0 = a0_; d0 = d0_; t0 = t0_;
      req1 = r1_; rd1 = rd1_; a1 = a1_; d1 = d1_; t1 = t1_;
   endtask

   task automatic settle(output logic e0, output logic e1);
      @(negedge clk);
      if (rst_n !== 1'b1) begin
         e0 = 1'b0;
         e1 = 1'b0;
      end else begin
`ifdef ARB2_FIXED_PRI_EN
         e0 = req0;
         e1 = req1 & ~req0;
`else
         e0 = req0 & (~req1 | m_ptr);
         e1 = req1 & (~req0 | ~m_ptr);
`endif
      end
      chk("gnt_0", 32'(gnt0), 32'(e0));
      chk("gnt_1", 32'(gnt1), 32'(e1));
      if (e0) push(1'b0, rd0, a0, d0, t0);
      if (e1) push(1'b1, rd1, a1, d1, t1);
      if (e0 | e1) m_ptr = e1;
   endtask

   task automatic idle(input int n);
      logic e0, e1;
      for (int i = 0; i < n; i++) begin
         drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
         settle(e0, e1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      logic e0, e1;
      int k0, k1, n0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      mem_rdata = '0;
      m_ptr = 1'b1;
      rst_n = 1'b0;
      req0 = 1; rd0 = 0; a0 = '0; d0 = 16'h0055; t0 = '0;
      req1 = 1; rd1 = 1; a1 = '0; d1 = '0;       t1 = 4'h3;

      // 1: reset with both requesting
      for (int i = 0; i < 3; i++) begin
         settle(e0, e1);
         chk("rst_mem_en", 32'(mem_en), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", 32'(mem_addr), 32'd0);
         chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
         chk("rst_rvalid", 32'(client_rvalid), 32'd0);
         chk("rst_rid", 32'(client_rid), 32'd0);
         chk("rst_rtag", 32'(client_rtag), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle(e0, e1);
      chk("first_tie_gnt0", 32'(e0), 32'd1);
      drive(0, 0, '0, '0, '0, 1, 1, '0, '0, 4'h3);
      settle(e0, e1);
      idle(3);

      // 2: client 0 write stream
      for (int i = 1; i <= 15; i++) begin
         drive(1, 0, AW'(i), W'(i), '0, 0, 0, '0, '0, '0);
         settle(e0, e1);
      end
      idle(2);

      // 3: client 1 read stream, tag = addr
      for (int i = 1; i <= 15; i++) begin
         drive(0, 0, '0, '0, '0, 1, 1, AW'(i), '0, TW'(i));
         settle(e0, e1);
      end
      idle(3);
      chk("t3_rd_q_empty", 32'(rd_q.size()), 32'd0);

      // 4: both continuously requesting
      k0 = 0; k1 = 0; n0 = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, AW'(32 + k0), W'(16'hA000 + k0), '0,
               1, 1, AW'(1 + (k1 % 15)), '0, TW'(k1));
         settle(e0, e1);
         if (e0) begin k0++; n0++; end
         if (e1) k1++;
      end
`ifdef ARB2_FIXED_PRI_EN
      chk("t4_gnt0_count", 32'(n0), 32'd8);
`else
      chk("t4_gnt0_count", 32'(n0), 32'd4);
`endif
      idle(3);

      // 5: client 0 idles 2 of 12 cycles, client 1 reads continuously
      k0 = 0; k1 = 0;
      for (int i = 0; i < 48; i++) begin
         drive(((i % 12) < 10), 0, AW'(64 + k0), W'(16'hB000 + k0), '0,
               1, 1, AW'(1 + (k1 % 15)), '0, TW'(k1));
         settle(e0, e1);
         if (e0) k0++;
         if (e1) k1++;
      end
      idle(3);
      chk("t5_cmd_q_empty", 32'(cmd_q.size()), 32'd0);
      chk("t5_rd_q_empty", 32'(rd_q.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, '0, '0, '0, 1, 1, AW'(64 + i), '0, TW'(i));
         settle(e0, e1);
      end
      idle(3);

      // 6: reset one cycle after a read grant
      drive(0, 0, '0, '0, '0, 1, 1, AW'(5), '0, 4'h9);
      settle(e0, e1);
      chk("t6_read_granted", 32'(e1), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req0 = 0; req1 = 0;
      cmd_q.delete();
      rd_q.delete();
      m_ptr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t6_rst_rvalid", 32'(client_rvalid), 32'd0);
         chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
         settle(e0, e1);
         chk("t6_post_rvalid", 32'(client_rvalid), 32'd0);
      end
      drive(1, 1, AW'(7), '0, 4'h1, 1, 1, AW'(8), '0, 4'h2);
      settle(e0, e1);
      chk("t6_tie_gnt0", 32'(e0), 32'd1);
      drive(0, 0, '0, '0, '0, 1, 1, AW'(8), '0, 4'h2);
      settle(e0, e1);
      idle(4);
      chk("end_cmd_q_empty", 32'(cmd_q.size()), 32'd0);
      chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
